// File: rtl/div32_seq.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, with a
// start/busy/ready handshake so the execute stage can stall on the result.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             neg_q;
    logic             neg_r;
    logic             zero;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] raw;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             carry;
    logic             unused_trial;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic s);
        return (s && x[WIDTH-1]) ? negate(x) : x;
    endfunction

    // Trial subtraction in adder form; the carry-out says the shifted remainder covers the divisor.
    assign shifted      = {rem, quo[WIDTH-1]};
    assign trial        = {1'b0, shifted} + {1'b0, ~{1'b0, dvs}} + (WIDTH+2)'(1);
    assign carry        = trial[WIDTH+1];
    assign unused_trial = trial[WIDTH];

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= IDLE;
            count <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            dz    <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= sign & dividend[WIDTH-1];
                        zero  <= (divisor == '0);
                        dvs   <= magnitude(divisor, sign);
                        quo   <= magnitude(dividend, sign);
                        rem   <= '0;
                        raw   <= dividend;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem   <= carry ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], carry};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero) begin
                        q  <= '1;
                        r  <= raw;
                        dz <= 1'b1;
                    end else begin
                        q  <= neg_q ? negate(quo) : quo;
                        r  <= neg_r ? negate(rem) : rem;
                        dz <= 1'b0;
                    end
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed and random checks of div32_seq: latency, signed/unsigned results,
// divide-by-zero, overflow, abort by reset and back-to-back operation.
module tb_div32_seq;

    logic        clk;
    logic        clrn;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        ready;
    logic        dz;

    int checks   = 0;
    int failures = 0;

    div32_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .ready    (ready),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble the operand ports after acceptance, then
    // check latency, busy span, results and the single-cycle ready pulse.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input string tag);
        int lat;
        int busy_cnt;
        sign     = s;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        sign     = ~s;
        lat      = 0;
        busy_cnt = 0;
        while (!ready && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd33);
        check({tag, "_busy"}, 32'(busy_cnt), 32'd33);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
        check({tag, "_busy_at_rdy"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_rdy_pulse"}, {31'd0, ready}, 32'd0);
        check({tag, "_q_hold"}, q, eq);
    endtask

    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er, output logic edz);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa  = a;
        sb  = b;
        edz = 1'b0;
        if (b == 32'd0) begin
            eq  = 32'hFFFF_FFFF;
            er  = a;
            edz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000;
            er = 32'd0;
        end else if (s) begin
            eq = sa / sb;
            er = sa % sb;
        end else begin
            eq = a / b;
            er = a % b;
        end
    endtask

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          ready_seen;
        int          gap;

        clrn     = 1'b0;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        tick();
        tick();
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_flags", {29'd0, busy, ready, dz}, 32'd0);
        clrn = 1'b1;
        tick();

        do_op(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, "divu_100_7");
        do_op(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, "div_m7_2");
        do_op(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, "div_7_m2");
        do_op(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, "div_m100_m7");
        do_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, "div_ovf");
        do_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, "divu_big");
        do_op(1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, "divu_zero");
        do_op(1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, "div_zero");
        do_op(1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, "div_zero_neg");
        do_op(1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, "divu_max_1");
        do_op(1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, "divu_small");

        // Abort: ignored start at cycle 10, reset at step 16, no ready afterwards.
        sign       = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        ready_seen = 0;
        for (int i = 1; i < 16; i++) begin
            if (i == 10) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd4;
            end else begin
                start = 1'b0;
            end
            tick();
            if (ready) ready_seen++;
        end
        start = 1'b0;
        check("abort_busy_mid", {31'd0, busy}, 32'd1);
        clrn = 1'b0;
        tick();
        check("abort_q", q, 32'd0);
        check("abort_r", r, 32'd0);
        check("abort_flags", {29'd0, busy, ready, dz}, 32'd0);
        clrn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready || busy) ready_seen++;
        end
        check("abort_no_ready", 32'(ready_seen), 32'd0);

        // Back-to-back: start held high, second op accepted in the ready cycle.
        sign     = 1'b0;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        dividend = 32'd1000;
        divisor  = 32'd3;
        gap      = 0;
        while (!ready && gap < 40) begin
            tick();
            gap++;
        end
        check("b2b_first_lat", 32'(gap), 32'd33);
        check("b2b_first_q", q, 32'd14);
        gap = 0;
        tick();
        gap++;
        check("b2b_busy_again", {31'd0, busy}, 32'd1);
        check("b2b_q_hold", q, 32'd14);
        while (!ready && gap < 40) begin
            tick();
            gap++;
        end
        start = 1'b0;
        check("b2b_gap", 32'(gap), 32'd34);
        check("b2b_second_q", q, 32'd333);
        check("b2b_second_r", r, 32'd1);
        tick();
        tick();
        check("b2b_idle", {30'd0, busy, ready}, 32'd0);

        // Random signed/unsigned pairs against the / and % model.
        for (int k = 0; k < 150; k++) begin
            s = k[0];
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (k % 37 == 5) b = 32'd0;
            if (k % 41 == 7) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            model(s, a, b, eq, er, edz);
            do_op(s, a, b, eq, er, edz, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
